// File: rtl/rgb_to_gray_stream.sv
// rgb_to_gray_stream: streaming RGB-to-gray converter, 3-stage fixed-point pipeline with line/frame markers
module rgb_to_gray_stream #(
  parameter int DATA_COLOR_WIDTH = 8,
  parameter int DATA_IN_WIDTH = 3*DATA_COLOR_WIDTH,
  parameter int FIXED_POINT_WIDTH = 32,
  parameter int POINT_POSITION = FIXED_POINT_WIDTH/2,
  parameter int IMAGE_WIDTH = 480,
  parameter int IMAGE_HEIGHT = 270,
  parameter int TOTAL_NUMBER_CONVERT = IMAGE_WIDTH*IMAGE_HEIGHT,
  parameter bit ROUND_EN = 1
)(
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic start,
  input  logic [1:0] mode,
  input  logic [FIXED_POINT_WIDTH-1:0] scale_red,
  input  logic [FIXED_POINT_WIDTH-1:0] scale_green,
  input  logic [FIXED_POINT_WIDTH-1:0] scale_blue,
  input  logic s_valid,
  output logic s_ready,
  input  logic [DATA_IN_WIDTH-1:0] s_data,
  output logic m_valid,
  input  logic m_ready,
  output logic [DATA_COLOR_WIDTH-1:0] m_data,
  output logic m_eol,
  output logic m_last,
  output logic busy,
  output logic frame_done
);
  localparam int DW = DATA_COLOR_WIDTH;
  localparam int FW = FIXED_POINT_WIDTH;
  localparam int PW = DW+FW;
  localparam int SW = PW+2;
  localparam int SL = POINT_POSITION >= 16 ? POINT_POSITION-16 : 0;
  localparam int SR = POINT_POSITION < 16 ? 16-POINT_POSITION : 0;
  localparam int CW = $clog2(IMAGE_WIDTH+1);
  localparam int NW = $clog2(TOTAL_NUMBER_CONVERT+1);
  localparam logic [CW-1:0] COL_END = CW'(IMAGE_WIDTH-1);
  localparam logic [NW-1:0] PIX_END = NW'(TOTAL_NUMBER_CONVERT-1);
  localparam logic [SW:0] RND = ROUND_EN ? (SW+1)'(1) << (POINT_POSITION-1) : '0;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic stall, s_hs, m_hs, v1, v2;
  logic [DW-1:0] r, g, b;
  logic [FW-1:0] cr, cg, cb;
  logic [PW-1:0] pr, pg, pb;
  logic [SW-1:0] sum;
  logic [SW:0] rs, sh;
  logic [CW-1:0] col;
  logic [NW-1:0] in_cnt, out_cnt;
  function automatic logic [FW-1:0] q16(input logic [FW-1:0] k);
    return (k << SL) >> SR;
  endfunction
  assign {r, g, b} = s_data[3*DW-1:0];
  assign stall = !en || (m_valid && !m_ready);
  assign s_ready = state == RUN && !stall;
  assign s_hs = s_valid && s_ready;
  assign m_hs = m_valid && !stall;
  assign m_eol = m_valid && col == COL_END;
  assign m_last = m_valid && out_cnt == PIX_END;
  assign busy = state == RUN || state == DRAIN;
  assign frame_done = state == DONE;
  assign rs = {1'b0, sum} + RND;
  assign sh = rs >> POINT_POSITION;
  // coefficient selection by weighting mode
  always_comb begin
    cr = mode == 2'd0 ? scale_red : mode == 2'd1 ? q16(FW'(19595)) : mode == 2'd2 ? q16(FW'(21845)) : '0;
    cg = mode == 2'd0 ? scale_green : mode == 2'd1 ? q16(FW'(38470)) : mode == 2'd2 ? q16(FW'(21845)) : FW'(1) << POINT_POSITION;
    cb = mode == 2'd0 ? scale_blue : mode == 2'd1 ? q16(FW'(7471)) : mode == 2'd2 ? q16(FW'(21845)) : '0;
  end
  // frame sequencing; everything freezes while stalled
  always_comb begin
    state_n = state;
    if (!stall)
      case (state)
        IDLE:    state_n = start ? RUN : IDLE;
        RUN:     state_n = s_hs && in_cnt == PIX_END ? DRAIN : RUN;
        DRAIN:   state_n = m_hs && m_last ? DONE : DRAIN;
        default: state_n = IDLE;
      endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // multiply, sum, then round/shift/saturate
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      m_valid <= 1'b0;
      pr <= '0;
      pg <= '0;
      pb <= '0;
      sum <= '0;
      m_data <= '0;
    end else if (!stall) begin
      v1 <= s_hs;
      pr <= {{FW{1'b0}}, r} * {{DW{1'b0}}, cr};
      pg <= {{FW{1'b0}}, g} * {{DW{1'b0}}, cg};
      pb <= {{FW{1'b0}}, b} * {{DW{1'b0}}, cb};
      v2 <= v1;
      sum <= {2'b0, pr} + {2'b0, pg} + {2'b0, pb};
      m_valid <= v2;
      m_data <= |sh[SW:DW] ? '1 : sh[DW-1:0];
    end
  // input pixel count and output column/pixel position
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      in_cnt <= '0;
      out_cnt <= '0;
      col <= '0;
    end else if (!stall) begin
      if (state == IDLE && start) begin
        in_cnt <= '0;
        out_cnt <= '0;
        col <= '0;
      end else begin
        if (s_hs) in_cnt <= in_cnt + 1'b1;
        if (m_hs) begin
          out_cnt <= out_cnt + 1'b1;
          col <= m_eol ? '0 : col + 1'b1;
        end
      end
    end
endmodule

// File: doc/rgb_to_gray_stream.md
Name: rgb_to_gray_stream

Overview:
Parametrised streaming successor to the BRAM-bound RGB-to-gray converter. Accepts packed RGB pixels on a valid/ready input and runs a 3-stage fixed-point pipeline. Emits gray pixels on a valid/ready output with line and frame markers. Sits between the pixel source (BRAM reader or DMA) and the gray-scale sink; frame size and colour depth are generics, and weighting mode is selectable at run time.

Parameters:
DATA_COLOR_WIDTH, 8, bits per colour channel and per gray output
DATA_IN_WIDTH, 3*DATA_COLOR_WIDTH, packed input width, {R,G,B} with R in MSBs
FIXED_POINT_WIDTH, 32, width of each scale coefficient
POINT_POSITION, FIXED_POINT_WIDTH/2, fractional bits of the coefficients
IMAGE_WIDTH, 480, pixels per line
IMAGE_HEIGHT, 270, lines per frame
TOTAL_NUMBER_CONVERT, IMAGE_WIDTH*IMAGE_HEIGHT, pixels per frame
ROUND_EN, 1, 1 = round half-up before truncation; 0 = truncate

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
en  in  1  global enable; 0 freezes the pipeline, FSM and counters
start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
mode  in  2  0 = user scales, 1 = BT.601 luma, 2 = average, 3 = green pass-through
scale_red  in  FIXED_POINT_WIDTH  red coefficient, unsigned Q(POINT_POSITION)
scale_green  in  FIXED_POINT_WIDTH  green coefficient
scale_blue  in  FIXED_POINT_WIDTH  blue coefficient
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid && s_ready
s_data  in  DATA_IN_WIDTH  packed RGB
m_valid  out  1  output pixel valid
m_ready  in  1  downstream ready
m_data  out  DATA_COLOR_WIDTH  gray value
m_eol  out  1  qualifies m_data as the last pixel of a line
m_last  out  1  qualifies m_data as the last pixel of the frame
busy  out  1  high in RUN and DRAIN
frame_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset: s_ready, m_valid, m_data, m_eol, m_last, busy and frame_done are 0. FSM goes to IDLE; all counters and pipeline valid bits are cleared.
- Reset asserted mid-frame aborts the frame immediately. No frame_done is produced.
- FSM states and transitions:
  - IDLE: start -> RUN; the input pixel counter and the output column/pixel counters clear.
  - RUN: accepts pixels; the handshake on pixel TOTAL_NUMBER_CONVERT-1 -> DRAIN.
  - DRAIN: s_ready=0; the output handshake with m_last -> DONE.
  - DONE: frame_done=1 for exactly one cycle -> IDLE.
  - start outside IDLE is ignored.
- Stall: stall = !en || (m_valid && !m_ready). On stall, every pipeline register, counter and FSM state holds.
- s_ready = (state==RUN) && !stall.
- Latency: exactly 3 clk from input handshake to m_valid when no stall. Throughput is 1 pixel/clk.
- Pipeline stages:
  - Stage 1 registers three products channel*coef, each DATA_COLOR_WIDTH+FIXED_POINT_WIDTH bits.
  - Stage 2 registers the sum, widened by 2 bits.
  - Stage 3 adds 2^(POINT_POSITION-1) if ROUND_EN, shifts right by POINT_POSITION, and saturates to 2^DATA_COLOR_WIDTH-1.
- Coefficients by mode. The Q16 constants are shifted left by (POINT_POSITION-16), or right if that value is negative.
  - Mode 0: scale_* inputs.
  - Mode 1: 19595 / 38470 / 7471.
  - Mode 2: 21845 each.
  - Mode 3: 0 / 2^POINT_POSITION / 0.
- mode and scale_* are sampled at stage 1 on every advancing cycle. Changing them mid-frame affects only subsequent pixels.
- m_eol is high when the output column counter equals IMAGE_WIDTH-1; the counter wraps to 0 on that handshake.
- m_last is high when the output pixel count equals TOTAL_NUMBER_CONVERT-1.
- m_data, m_eol and m_last hold stable while m_valid && !m_ready.
- frame_done rises the cycle after the m_last handshake.

Test Plan:
- Mode 0, scales 16384 (0.25) each, pixel (200,100,40), m_ready=1 -> m_data=85 exactly 3 clk after the handshake.
- Mode 0, scales 65536 each, pixel (255,255,255) -> saturates to 255.
- Rounding, mode 0, scales (32768,0,0), R=3 -> 2 with ROUND_EN=1 and 1 with ROUND_EN=0. Mode 1, pixel (255,0,0) -> 76.
- IMAGE_WIDTH=4, IMAGE_HEIGHT=2, 8 pixels streamed -> m_eol on outputs 4 and 8, m_last on output 8, frame_done one cycle later, then IDLE with s_ready=0.
- Backpressure: m_ready toggled randomly with en dropped for 5 cycles mid-frame -> no lost or duplicated pixels, output held stable while stalled, order preserved against the reference model.
- reset_n pulsed low after 3 of 8 pixels -> all outputs 0 at once, no frame_done; a new start yields a full 8-pixel frame.
